regfile_bank: RTL
=================

REGFILE_BANK -- requirements
Module: regfile_bank

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the register width in bits.
REQ-002 Parameter ADDR_W, default 3, SHALL set the address width; NUM_REGS = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 0, SHALL hardwire register 0 to zero when set to 1.
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 rd_addr_a, rd_addr_b  in  ADDR_W  SHALL be the read-port addresses.
REQ-007 rd_data_a, rd_data_b  out  DATA_W  SHALL be the read data.
REQ-008 rd_busy_a, rd_busy_b  out  1  SHALL be the scoreboard busy bit of the addressed register.
REQ-009 wr_en_0, wr_en_1  in  1  SHALL be the write enables of write ports 0 and 1.
REQ-010 wr_addr_0, wr_addr_1  in  ADDR_W  SHALL be the write addresses.
REQ-011 wr_data_0, wr_data_1  in  DATA_W  SHALL be the write data.
REQ-012 rsv_valid  in  1  SHALL request reservation (mark pending write) of rsv_addr.
REQ-013 rsv_addr  in  ADDR_W  SHALL be the register to reserve.
REQ-014 rsv_ready  out  1  SHALL accept the reservation; transfer occurs on rsv_valid && rsv_ready at the clock edge.
REQ-015 busy_vec  out  NUM_REGS  SHALL expose all busy bits, bit i = register i.
REQ-016 wr_collide  out  1  SHALL be a registered one-cycle pulse flagging a dual-port same-address write.

Function
REQ-017 Reads SHALL be combinational, zero latency, from the current register contents.
REQ-018 Writes SHALL update the addressed register at the rising edge when wr_en_x = 1.
REQ-019 Both ports enabled, same address: port 1 SHALL win; wr_collide = 1 in the following cycle only.
REQ-020 Both ports enabled, different addresses: both writes SHALL complete in the same cycle.
REQ-021 rsv_ready SHALL equal !busy[rsv_addr], purely combinational, independent of rsv_valid.
REQ-022 Accepted reservation SHALL set busy[rsv_addr] at the edge; a rejected one SHALL change nothing.
REQ-023 A write to register i SHALL clear busy[i] at the edge; a write to a non-busy register SHALL leave it 0.
REQ-024 Accepted reservation and write to the same non-busy register in one cycle: busy SHALL end set (reserve wins).
REQ-025 Busy bit per register SHALL form a 2-state FSM: IDLE -> PENDING on accepted reserve; PENDING -> IDLE on write.
REQ-026 ZERO_REG = 1: register 0 SHALL read 0, ignore writes, never become busy, rsv_ready = 1 for address 0, and a port-collision on address 0 SHALL NOT pulse wr_collide.
REQ-027 rd_busy_x SHALL reflect busy bits before the current edge (no bypass of scoreboard updates).

Reset
REQ-028 On reset_n = 0, all registers, busy_vec and wr_collide SHALL clear to 0 asynchronously.
REQ-029 During reset, read data SHALL be 0, rsv_ready = 1, and writes/reservations SHALL be ignored.
REQ-030 Reset deasserted mid-operation SHALL leave no pending reservation; first edge after release behaves normally.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN defined: a read whose address matches an enabled write in the same cycle SHALL return that write data (port 1 priority), except register 0 under ZERO_REG.
REQ-032 REGFILE_BYPASS_EN undefined: reads SHALL return the pre-edge register contents.

Structure
REQ-033 Package regfile_pkg SHALL hold default DATA_W/ADDR_W constants and the busy-state typedef (IDLE, PENDING).
REQ-034 Scoreboard logic SHALL be one sub-module, regfile_scoreboard, holding busy_vec, rsv_ready and wr_collide.

Verification
REQ-035 Reset, then read all 8 addresses -> all 0x0000; busy_vec = 0x00; rsv_ready = 1.
REQ-036 wr_en_0 addr 3 data 0xA5A5, wr_en_1 addr 5 data 0x1234 same cycle -> next cycle r3 = 0xA5A5, r5 = 0x1234, wr_collide = 0.
REQ-037 Both ports write addr 2 (0x1111 / 0x2222) -> r2 = 0x2222, wr_collide = 1 for exactly one cycle.
REQ-038 Reserve r4 -> busy_vec = 0x10; reserve r4 again -> rsv_ready = 0, no change; write r4 0x0F0F -> busy_vec = 0x00, r4 = 0x0F0F.
REQ-039 Write r6 = 0xBEEF while reading r6: with REGFILE_BYPASS_EN rd_data = 0xBEEF same cycle; without, old value, then 0xBEEF next cycle.
REQ-040 ZERO_REG = 1: write r0 0xFFFF and reserve r0 -> r0 reads 0x0000, busy_vec[0] = 0; assert reset_n low mid-reservation -> busy_vec = 0 immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared default widths and per-register busy state for the register bank
package regfile_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 3;
   typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} busy_state_t;
endpackage

// File: rtl/regfile_bank_if.sv
// regfile_bank_if: read, write and reservation signals of the register bank
interface regfile_bank_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   localparam int NUM_REGS = 2**ADDR_W;
   logic [ADDR_W-1:0]   rd_addr_a, rd_addr_b;
   logic [DATA_W-1:0]   rd_data_a, rd_data_b;
   logic                rd_busy_a, rd_busy_b;
   logic                wr_en_0, wr_en_1;
   logic [ADDR_W-1:0]   wr_addr_0, wr_addr_1;
   logic [DATA_W-1:0]   wr_data_0, wr_data_1;
   logic                rsv_valid;
   logic [ADDR_W-1:0]   rsv_addr;
   logic                rsv_ready;
   logic [NUM_REGS-1:0] busy_vec;
   logic                wr_collide;
   modport master (
      output rd_addr_a, rd_addr_b, wr_en_0, wr_en_1, wr_addr_0, wr_addr_1,
             wr_data_0, wr_data_1, rsv_valid, rsv_addr,
      input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, rsv_ready, busy_vec, wr_collide
   );
   modport slave (
      input  rd_addr_a, rd_addr_b, wr_en_0, wr_en_1, wr_addr_0, wr_addr_1,
             wr_data_0, wr_data_1, rsv_valid, rsv_addr,
      output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, rsv_ready, busy_vec, wr_collide
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write tracking, reservation handshake, collision pulse
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   i_wr_en_0,
   input  logic [ADDR_W-1:0]      i_wr_addr_0,
   input  logic                   i_wr_en_1,
   input  logic [ADDR_W-1:0]      i_wr_addr_1,
   input  logic                   i_rsv_valid,
   input  logic [ADDR_W-1:0]      i_rsv_addr,
   output logic                   o_rsv_ready,
   output logic [2**ADDR_W-1:0]   o_busy_vec,
   output logic                   o_wr_collide
);
   localparam int NUM_REGS = 2**ADDR_W;
   busy_state_t r_state [NUM_REGS];
   busy_state_t w_next  [NUM_REGS];
   logic        w_we_0, w_we_1, w_accept, r_collide;
   // a hardwired register 0 takes part in neither writes nor reservations
   assign w_we_0      = i_wr_en_0 && !(ZERO_REG != 0 && i_wr_addr_0 == '0);
   assign w_we_1      = i_wr_en_1 && !(ZERO_REG != 0 && i_wr_addr_1 == '0);
   assign o_rsv_ready = !o_busy_vec[i_rsv_addr];
   assign w_accept    = i_rsv_valid && o_rsv_ready && !(ZERO_REG != 0 && i_rsv_addr == '0);
   assign o_wr_collide = r_collide;
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_busy
      assign o_busy_vec[g] = (r_state[g] == PENDING);
   end
   // a reservation landing with a write to the same register leaves it pending
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++)
         w_next[i] = (w_accept && i_rsv_addr == ADDR_W'(i)) ? PENDING :
                     ((w_we_0 && i_wr_addr_0 == ADDR_W'(i)) ||
                      (w_we_1 && i_wr_addr_1 == ADDR_W'(i))) ? IDLE : r_state[i];
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) r_state[i] <= IDLE;
         r_collide <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_collide <= w_we_0 && w_we_1 && (i_wr_addr_0 == i_wr_addr_1);
      end
   end
endmodule

// File: rtl/regfile_bank.sv
// regfile_bank: 2-read/2-write register bank with busy scoreboard; REGFILE_BYPASS_EN forwards same-cycle writes to reads
module regfile_bank
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 0
) (
   input  logic           clk,
   input  logic           reset_n,
   regfile_bank_if.slave  io_bus
);
   localparam int NUM_REGS = 2**ADDR_W;
   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic                w_we_0, w_we_1, w_rsv_ready, w_collide;
   logic [NUM_REGS-1:0] w_busy_vec;
   // gating with reset_n keeps forwarded data out of reads while in reset
   assign w_we_0 = reset_n && io_bus.wr_en_0 && !(ZERO_REG != 0 && io_bus.wr_addr_0 == '0);
   assign w_we_1 = reset_n && io_bus.wr_en_1 && !(ZERO_REG != 0 && io_bus.wr_addr_1 == '0);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else begin
         if (w_we_0) r_regs[io_bus.wr_addr_0] <= io_bus.wr_data_0;
         if (w_we_1) r_regs[io_bus.wr_addr_1] <= io_bus.wr_data_1;
      end
   end
`ifdef REGFILE_BYPASS_EN
   assign io_bus.rd_data_a = (w_we_1 && io_bus.wr_addr_1 == io_bus.rd_addr_a) ? io_bus.wr_data_1 :
                             (w_we_0 && io_bus.wr_addr_0 == io_bus.rd_addr_a) ? io_bus.wr_data_0 :
                             r_regs[io_bus.rd_addr_a];
   assign io_bus.rd_data_b = (w_we_1 && io_bus.wr_addr_1 == io_bus.rd_addr_b) ? io_bus.wr_data_1 :
                             (w_we_0 && io_bus.wr_addr_0 == io_bus.rd_addr_b) ? io_bus.wr_data_0 :
                             r_regs[io_bus.rd_addr_b];
`else
   assign io_bus.rd_data_a = r_regs[io_bus.rd_addr_a];
   assign io_bus.rd_data_b = r_regs[io_bus.rd_addr_b];
`endif
   regfile_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_scoreboard (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_wr_en_0    (io_bus.wr_en_0),
      .i_wr_addr_0  (io_bus.wr_addr_0),
      .i_wr_en_1    (io_bus.wr_en_1),
      .i_wr_addr_1  (io_bus.wr_addr_1),
      .i_rsv_valid  (io_bus.rsv_valid),
      .i_rsv_addr   (io_bus.rsv_addr),
      .o_rsv_ready  (w_rsv_ready),
      .o_busy_vec   (w_busy_vec),
      .o_wr_collide (w_collide)
   );
   assign io_bus.rsv_ready  = w_rsv_ready;
   assign io_bus.busy_vec   = w_busy_vec;
   assign io_bus.wr_collide = w_collide;
   assign io_bus.rd_busy_a  = w_busy_vec[io_bus.rd_addr_a];
   assign io_bus.rd_busy_b  = w_busy_vec[io_bus.rd_addr_b];
endmodule
